// File: rtl/fpu_share_arbiter_if.sv
// Requester and function-unit signal bundle for the shared FPU port.
// master = arbiter side, slave = requesters plus function unit.
interface fpu_share_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*8-1:0]  req_op;
    logic [NREQ*42-1:0] req_a;
    logic [NREQ*42-1:0] req_b;
    logic [NREQ-1:0]    rsp_valid;
    logic [41:0]        rsp_data;
    logic               rsp_error;
    logic               fu_eval;
    logic [7:0]         fu_op;
    logic [41:0]        fu_a;
    logic [41:0]        fu_b;
    logic               fu_done;
    logic [41:0]        fu_res;
    logic               busy;

    modport master (
        input  req_valid, req_op, req_a, req_b,
        input  fu_done, fu_res,
        output req_ready, rsp_valid, rsp_data, rsp_error,
        output fu_eval, fu_op, fu_a, fu_b, busy
    );

    modport slave (
        output req_valid, req_op, req_a, req_b,
        output fu_done, fu_res,
        input  req_ready, rsp_valid, rsp_data, rsp_error,
        input  fu_eval, fu_op, fu_a, fu_b, busy
    );
endinterface

// File: rtl/fpu_share_arbiter.sv
// Round-robin sharing of one FPU port among NREQ requesters,
// with opcode legality check and a WAIT-state watchdog.
module fpu_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4095
) (
    input  logic                clock,
    input  logic                reset,
    fpu_share_arbiter_if.master bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    state_e          state_q;
    logic [PW-1:0]   rr_q;
    logic [TW-1:0]   timer_q;
    logic [PW-1:0]   id_q;
    logic            fu_eval_q;
    logic [7:0]      fu_op_q;
    logic [41:0]     fu_a_q;
    logic [41:0]     fu_b_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic [41:0]     rsp_data_q;
    logic            rsp_error_q;
    logic            busy_q;

    logic            found;
    logic [PW-1:0]   gid;
    logic [PW-1:0]   rr_d;
    logic [NREQ-1:0] gnt;
    logic [7:0]      op_s;
    logic [41:0]     a_s;
    logic [41:0]     b_s;
    logic            legal_s;
    logic            unary_s;
    int              j;

    always_comb begin
        found = 1'b0;
        gid   = '0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && bus.req_valid[j]) begin
                found = 1'b1;
                gid   = PW'(j);
            end
        end
        rr_d = (gid == PW'(NREQ - 1)) ? '0 : gid + PW'(1);
        gnt  = '0;
        if (state_q == IDLE && !reset && found) gnt[gid] = 1'b1;
    end

    always_comb begin
        op_s    = bus.req_op[int'(gid)*8 +: 8];
        a_s     = bus.req_a[int'(gid)*42 +: 42];
        b_s     = bus.req_b[int'(gid)*42 +: 42];
        legal_s = 1'b0;
        unary_s = 1'b0;
        case (op_s)
            8'h2A, 8'h2B, 8'h2C, 8'h2D, 8'hF2, 8'hF3: legal_s = 1'b1;
            8'hF0, 8'hF1, 8'hF4, 8'hF5, 8'hF6: begin
                legal_s = 1'b1;
                unary_s = 1'b1;
            end
            default: legal_s = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            timer_q     <= '0;
            id_q        <= '0;
            fu_eval_q   <= 1'b0;
            fu_op_q     <= '0;
            fu_a_q      <= '0;
            fu_b_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (found) begin
                    id_q   <= gid;
                    rr_q   <= rr_d;
                    busy_q <= 1'b1;
                    if (legal_s) begin
                        state_q   <= ISSUE;
                        fu_eval_q <= 1'b1;
                        fu_op_q   <= op_s;
                        fu_a_q    <= a_s;
                        fu_b_q    <= unary_s ? '0 : b_s;
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= NREQ'(1) << gid;
                        rsp_data_q  <= '0;
                        rsp_error_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    fu_eval_q <= 1'b0;
                    timer_q   <= '0;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    // Completion takes priority over an expiring watchdog.
                    if (bus.fu_done || timer_q == TW'(TIMEOUT - 1)) begin
                        state_q     <= RESP;
                        rsp_valid_q <= NREQ'(1) << id_q;
                        rsp_data_q  <= bus.fu_done ? bus.fu_res : '0;
                        rsp_error_q <= !bus.fu_done;
                        fu_op_q     <= '0;
                        fu_a_q      <= '0;
                        fu_b_q      <= '0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= '0;
                    rsp_data_q  <= '0;
                    rsp_error_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.fu_eval   = fu_eval_q;
    assign bus.fu_op     = fu_op_q;
    assign bus.fu_a      = fu_a_q;
    assign bus.fu_b      = fu_b_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Bench for fpu_share_arbiter: transaction-timeline model checked every
// cycle, plus literal latency/grant-order expectations.
module tb_fpu_share_arbiter;
    localparam int NREQ = 4;
    localparam int TO   = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fpu_share_arbiter_if #(.NREQ(NREQ)) bus ();

    fpu_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // function-unit model: done pulse `lat` cycles after the eval cycle
    int          lat     = 1;
    bit          fu_en   = 1'b0;
    int          done_at = -1;
    logic [41:0] res_val = '0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #1;
        bus.fu_done = fu_en && (cyc == done_at);
        bus.fu_res  = res_val;
    end

    function automatic bit is_legal(logic [7:0] op);
        return op inside {8'h2A, 8'h2B, 8'h2C, 8'h2D, 8'hF2, 8'hF3,
                          8'hF0, 8'hF1, 8'hF4, 8'hF5, 8'hF6};
    endfunction

    function automatic bit is_unary(logic [7:0] op);
        return op inside {8'hF0, 8'hF1, 8'hF4, 8'hF5, 8'hF6};
    endfunction

    // model: one transaction record, outputs derived from cycle offsets
    int          m_rr  = 0;
    bit          t_act = 1'b0;
    int          t_id, t_g, t_resp;
    bit          t_legal, t_err;
    logic [7:0]  t_op;
    logic [41:0] t_a, t_b, t_data;

    // DUT observations for the literal checks
    int          hs_n = 0, rsp_n = 0, ev_n = 0;
    int          hs_cyc, ev_cyc, rsp_cyc;
    logic [3:0]  rsp_vec;
    logic [41:0] rsp_dat, ev_a, ev_b;
    logic        rsp_err;
    int          gq[$];

    always @(negedge clock) begin
        logic [NREQ-1:0] e_rdy, e_rv;
        logic [41:0] e_data, e_a, e_b;
        logic [7:0] e_op;
        logic e_err, e_eval, e_busy;
        int g;
        e_rdy = '0; e_rv = '0; e_data = '0; e_a = '0; e_b = '0;
        e_op = '0; e_err = 1'b0; e_eval = 1'b0; e_busy = 1'b0;
        g = -1;
        if (reset) begin
            t_act = 1'b0;
            m_rr  = 0;
        end else if (!t_act) begin
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && bus.req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
            if (g >= 0) begin
                e_rdy[g] = 1'b1;
                t_act   = 1'b1;
                t_id    = g;
                t_g     = cyc;
                t_op    = bus.req_op[g*8 +: 8];
                t_a     = bus.req_a[g*42 +: 42];
                t_b     = bus.req_b[g*42 +: 42];
                t_legal = is_legal(t_op);
                t_resp  = t_legal ? -1 : cyc + 1;
                t_err   = !t_legal;
                t_data  = '0;
                m_rr    = (g + 1) % NREQ;
            end
        end else begin
            e_busy = 1'b1;
            if (t_legal && t_resp < 0 && cyc >= t_g + 2) begin
                if (bus.fu_done) begin
                    t_resp = cyc + 1; t_data = bus.fu_res; t_err = 1'b0;
                end else if (cyc == t_g + 1 + TO) begin
                    t_resp = cyc + 1; t_data = '0; t_err = 1'b1;
                end
            end
            if (cyc == t_resp) begin
                e_rv[t_id] = 1'b1;
                e_data = t_data;
                e_err  = t_err;
                t_act  = 1'b0;
            end else begin
                e_eval = (cyc == t_g + 1);
                e_op   = t_op;
                e_a    = t_a;
                e_b    = is_unary(t_op) ? '0 : t_b;
            end
        end
        chk("req_ready", bus.req_ready, e_rdy);
        chk("rsp_valid", bus.rsp_valid, e_rv);
        chk("rsp_data", bus.rsp_data, e_data);
        chk("rsp_error", bus.rsp_error, e_err);
        chk("fu_eval", bus.fu_eval, e_eval);
        chk("fu_op", bus.fu_op, e_op);
        chk("fu_a", bus.fu_a, e_a);
        chk("fu_b", bus.fu_b, e_b);
        chk("busy", bus.busy, e_busy);

        for (int i = 0; i < NREQ; i++)
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                hs_n++; hs_cyc = cyc; gq.push_back(i);
            end
        if (bus.fu_eval) begin
            ev_n++; ev_cyc = cyc; ev_a = bus.fu_a; ev_b = bus.fu_b;
            done_at = cyc + lat;
        end
        if (|bus.rsp_valid) begin
            rsp_n++; rsp_cyc = cyc; rsp_vec = bus.rsp_valid;
            rsp_dat = bus.rsp_data; rsp_err = bus.rsp_error;
        end
    end

    task automatic issue(int i, logic [7:0] op, logic [41:0] a, logic [41:0] b);
        int h;
        bit ok;
        h  = hs_n;
        ok = 1'b0;
        bus.req_op[i*8 +: 8]  = op;
        bus.req_a[i*42 +: 42] = a;
        bus.req_b[i*42 +: 42] = b;
        bus.req_valid[i] = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(posedge clock);
            ok = (hs_n != h);
        end
        #1 bus.req_valid[i] = 1'b0;
        chk("handshake_timeout", ok, 1'b1);
    endtask

    task automatic wait_rsp(int n0, int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(posedge clock);
            ok = (rsp_n > n0);
        end
        #1;
        chk("rsp_timeout", ok, 1'b1);
    endtask

    initial begin
        int n0, e0;
        bit ok;
        bus.req_valid = '0; bus.req_op = '0;
        bus.req_a = '0; bus.req_b = '0;
        bus.fu_done = 1'b0; bus.fu_res = '0;
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 4'b0);
        chk("rst_fu_eval", bus.fu_eval, 1'b0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // all requesters held: grant order 0,1,2,3,0
        fu_en = 1'b1; lat = 1; res_val = 42'h77;
        gq.delete(); n0 = rsp_n;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_op[i*8 +: 8] = 8'h2A + 8'(i);
            bus.req_a[i*42 +: 42] = 42'(i + 16);
            bus.req_b[i*42 +: 42] = 42'(i + 32);
        end
        bus.req_valid = '1;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(posedge clock);
            ok = (rsp_n >= n0 + 5);
        end
        #1 bus.req_valid = '0;
        chk("t2_done", ok, 1'b1);
        chk("t2_ngrant", gq.size(), 5);
        chk("t2_g0", gq.size() > 0 ? gq[0] : -1, 0);
        chk("t2_g1", gq.size() > 1 ? gq[1] : -1, 1);
        chk("t2_g2", gq.size() > 2 ? gq[2] : -1, 2);
        chk("t2_g3", gq.size() > 3 ? gq[3] : -1, 3);
        chk("t2_g4", gq.size() > 4 ? gq[4] : -1, 0);
        chk("t2_last_rsp", rsp_vec, 4'b0001);
        repeat (2) @(posedge clock);
        #1;

        // basic add, latency 3
        lat = 3; res_val = 42'h123; n0 = rsp_n;
        issue(0, 8'h2A, 42'h1, 42'h2);
        wait_rsp(n0, 20);
        chk("t1_eval_lat", ev_cyc - hs_cyc, 1);
        chk("t1_rsp_lat", rsp_cyc - hs_cyc, 5);
        chk("t1_rsp_vec", rsp_vec, 4'b0001);
        chk("t1_rsp_data", rsp_dat, 42'h123);
        chk("t1_rsp_err", rsp_err, 1'b0);

        // illegal opcode
        n0 = rsp_n; e0 = ev_n;
        issue(2, 8'h41, 42'h5, 42'h6);
        wait_rsp(n0, 10);
        chk("t3_no_eval", ev_n, e0);
        chk("t3_rsp_lat", rsp_cyc - hs_cyc, 1);
        chk("t3_rsp_vec", rsp_vec, 4'b0100);
        chk("t3_rsp_err", rsp_err, 1'b1);
        chk("t3_rsp_data", rsp_dat, 42'h0);

        // watchdog, then a late fu_done in IDLE
        fu_en = 1'b0; n0 = rsp_n;
        issue(3, 8'h2C, 42'h9, 42'hA);
        wait_rsp(n0, 40);
        chk("t4_rsp_vec", rsp_vec, 4'b1000);
        chk("t4_rsp_err", rsp_err, 1'b1);
        chk("t4_rsp_data", rsp_dat, 42'h0);
        chk("t4_wait_len", rsp_cyc - ev_cyc, TO + 1);
        done_at = cyc + 1; fu_en = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("t4_late_ignored", rsp_n, n0 + 1);
        lat = 2; res_val = 42'h2BAD; n0 = rsp_n;
        issue(0, 8'h2B, 42'h11, 42'h22);
        wait_rsp(n0, 20);
        chk("t4_next_err", rsp_err, 1'b0);
        chk("t4_next_data", rsp_dat, 42'h2BAD);

        // reset during WAIT
        fu_en = 1'b0; n0 = rsp_n;
        issue(1, 8'h2D, 42'h3, 42'h4);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        chk("t5_busy", bus.busy, 1'b0);
        chk("t5_fu_op", bus.fu_op, 8'h0);
        chk("t5_fu_a", bus.fu_a, 42'h0);
        chk("t5_rsp_valid", bus.rsp_valid, 4'b0);
        bus.req_op[8 +: 8] = 8'h2A;
        bus.req_op[24 +: 8] = 8'h2A;
        bus.req_valid[1] = 1'b1;
        bus.req_valid[3] = 1'b1;
        fu_en = 1'b1; lat = 1; res_val = 42'h55;
        repeat (2) @(posedge clock);
        chk("t5_rdy_in_reset", bus.req_ready, 4'b0);
        #1 reset = 1'b0;
        gq.delete();
        chk("t5_no_rsp", rsp_n, n0);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(posedge clock);
            ok = (gq.size() >= 1);
        end
        #1 bus.req_valid[1] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(posedge clock);
            ok = (gq.size() >= 2);
        end
        #1 bus.req_valid[3] = 1'b0;
        chk("t5_first", gq.size() > 0 ? gq[0] : -1, 1);
        chk("t5_second", gq.size() > 1 ? gq[1] : -1, 3);
        repeat (8) @(posedge clock);
        #1;

        // unary op: operand B suppressed
        lat = 2; res_val = 42'h3A5; n0 = rsp_n;
        issue(1, 8'hF4, 42'h155, 42'h3FF);
        wait_rsp(n0, 20);
        chk("t6_fu_a", ev_a, 42'h155);
        chk("t6_fu_b", ev_b, 42'h0);
        chk("t6_rsp_vec", rsp_vec, 4'b0010);
        chk("t6_rsp_data", rsp_dat, 42'h3A5);
        repeat (3) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
